// File: rtl/logic_probe_pkg.sv
// rtl/logic_probe_pkg.sv - shared constants, state encoding and frame builder for the probe threshold DAC
package logic_probe_pkg;

    localparam logic [1:0] ADDR_THR_LO = 2'd0;
    localparam logic [1:0] ADDR_THR_HI = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int FRM_CH    = 15;
    localparam int FRM_BUF   = 14;
    localparam int FRM_GAIN  = 13;
    localparam int FRM_NSHDN = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_GAP,
        ST_LDAC
    } state_t;

    // Unbuffered reference, 1x gain, output enabled.
    function automatic logic [15:0] dac_frame(input logic ch, input logic [11:0] value);
        logic [15:0] f;
        f            = '0;
        f[11:0]      = value;
        f[FRM_CH]    = ch;
        f[FRM_BUF]   = 1'b0;
        f[FRM_GAIN]  = 1'b1;
        f[FRM_NSHDN] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/spi_tx16.sv
// rtl/spi_tx16.sv - 16-bit MSB-first SPI shifter with programmable SCK half-period
module spi_tx16 #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        load,
    input  logic [15:0] frame,
    input  logic        start,
    output logic        sck,
    output logic        mosi,
    output logic        done
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [14:0] shreg;
    logic [15:0] div;
    logic [3:0]  bitcnt;
    logic        active;
    logic        tick;

    assign tick = active && (div == DIV_LAST);
    // Asserted in the cycle whose closing edge is the 16th falling SCK edge.
    assign done = tick && sck && (bitcnt == 4'd15);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shreg  <= '0;
            div    <= '0;
            bitcnt <= '0;
            active <= 1'b0;
            sck    <= 1'b0;
            mosi   <= 1'b0;
        end else begin
            if (load) begin
                shreg <= frame[14:0];
                mosi  <= frame[15];
            end
            if (start) begin
                active <= 1'b1;
                div    <= '0;
                bitcnt <= '0;
                sck    <= 1'b0;
            end else if (active) begin
                if (tick) begin
                    div <= '0;
                    sck <= ~sck;
                    if (sck) begin
                        if (bitcnt == 4'd15) begin
                            active <= 1'b0;
                            mosi   <= 1'b0;
                        end else begin
                            bitcnt <= bitcnt + 4'd1;
                            mosi   <= shreg[14];
                            shreg  <= {shreg[13:0], 1'b0};
                        end
                    end
                end else begin
                    div <= div + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/logic_probe_dac.sv
// rtl/logic_probe_dac.sv - threshold registers and dual-channel SPI DAC update sequencer
module logic_probe_dac
    import logic_probe_pkg::*;
#(
    parameter int          CLK_DIV     = 4,
    parameter int          LDAC_CYCLES = 2,
    parameter logic [11:0] LO_RESET    = 12'h400,
    parameter logic [11:0] HI_RESET    = 12'hC00
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        req,
    input  logic        wr,
    output logic        ready,
    output logic        dac_sck,
    output logic        dac_mosi,
    output logic        dac_ncs,
    output logic        dac_nldac,
    output logic        busy
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] LDAC_LAST = 16'(LDAC_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        ch, ch_n;
    logic [11:0] thr_lo, thr_hi, shadow_hi;
    logic        pending;
    logic        consume;
    logic        wr_hit;
    logic        set_pending;
    logic        spi_load, spi_start, spi_done;
    logic [15:0] spi_frame;
    logic        unused_bits;

    assign unused_bits = ^data_in[31:12];

    assign wr_hit      = req && wr;
    assign set_pending = wr_hit && ((address == ADDR_THR_LO) || (address == ADDR_THR_HI) ||
                                    ((address == ADDR_CTRL) && data_in[0]));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ch_n      = ch;
        consume   = 1'b0;
        spi_load  = 1'b0;
        spi_start = 1'b0;
        spi_frame = dac_frame(1'b0, thr_lo);
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    consume  = 1'b1;
                    spi_load = 1'b1;
                    ch_n     = 1'b0;
                    cnt_n    = '0;
                    state_n  = ST_START;
                end
            end
            ST_START: begin
                if (cnt == DIV_LAST) begin
                    spi_start = 1'b1;
                    state_n   = ST_SHIFT;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (spi_done) begin
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (!ch) begin
                        ch_n      = 1'b1;
                        spi_load  = 1'b1;
                        spi_frame = dac_frame(1'b1, shadow_hi);
                        state_n   = ST_START;
                    end else begin
                        state_n = ST_LDAC;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            ST_LDAC: begin
                if (cnt == LDAC_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it glitch-free.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ch        <= 1'b0;
            dac_ncs   <= 1'b1;
            dac_nldac <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ch        <= ch_n;
            dac_ncs   <= !((state_n == ST_START) || (state_n == ST_SHIFT));
            dac_nldac <= (state_n != ST_LDAC);
            busy      <= (state_n != ST_IDLE);
        end
    end

    // A write in the same cycle the sequencer consumes pending keeps it set.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            thr_lo    <= LO_RESET;
            thr_hi    <= HI_RESET;
            shadow_hi <= HI_RESET;
            pending   <= 1'b1;
            ready     <= 1'b0;
            data_out  <= '0;
        end else begin
            ready <= req;
            if (wr_hit && (address == ADDR_THR_LO)) thr_lo <= data_in[11:0];
            if (wr_hit && (address == ADDR_THR_HI)) thr_hi <= data_in[11:0];
            if (consume) shadow_hi <= thr_hi;
            if (set_pending)  pending <= 1'b1;
            else if (consume) pending <= 1'b0;
            if (req && !wr) begin
                case (address)
                    ADDR_THR_LO: data_out <= {20'h0, thr_lo};
                    ADDR_THR_HI: data_out <= {20'h0, thr_hi};
                    ADDR_CTRL:   data_out <= {30'h0, pending, busy};
                    default:     data_out <= 32'h0;
                endcase
            end
        end
    end

    spi_tx16 #(
        .CLK_DIV(CLK_DIV)
    ) u_spi (
        .clk    (clk),
        .nreset (nreset),
        .load   (spi_load),
        .frame  (spi_frame),
        .start  (spi_start),
        .sck    (dac_sck),
        .mosi   (dac_mosi),
        .done   (spi_done)
    );

endmodule

// File: tb/tb_logic_probe_dac.sv
// tb/tb_logic_probe_dac.sv - directed bench for logic_probe_dac with SPI frame decoding
module tb_logic_probe_dac;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        nreset_s = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] data_in = 32'h0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] data_out, d1, d7;
    logic        ready, r1, r7;
    logic [2:0]  sck, mosi, ncs, nldac, busy;
    logic [1:0]  zaddr = 2'd0;
    logic [31:0] zdata = 32'h0;
    logic        zero = 1'b0;
    wire  [2:0]  rstn_v = {nreset_s, nreset_s, nreset};

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_probe_dac dut (
        .clk(clk), .nreset(nreset), .address(address), .data_in(data_in), .data_out(data_out),
        .req(req), .wr(wr), .ready(ready), .dac_sck(sck[0]), .dac_mosi(mosi[0]),
        .dac_ncs(ncs[0]), .dac_nldac(nldac[0]), .busy(busy[0])
    );

    logic_probe_dac #(.CLK_DIV(1)) dut1 (
        .clk(clk), .nreset(nreset_s), .address(zaddr), .data_in(zdata), .data_out(d1),
        .req(zero), .wr(zero), .ready(r1), .dac_sck(sck[1]), .dac_mosi(mosi[1]),
        .dac_ncs(ncs[1]), .dac_nldac(nldac[1]), .busy(busy[1])
    );

    logic_probe_dac #(.CLK_DIV(7)) dut7 (
        .clk(clk), .nreset(nreset_s), .address(zaddr), .data_in(zdata), .data_out(d7),
        .req(zero), .wr(zero), .ready(r7), .dac_sck(sck[2]), .dac_mosi(mosi[2]),
        .dac_ncs(ncs[2]), .dac_nldac(nldac[2]), .busy(busy[2])
    );

    // SPI/strobe decoder, sampled on the falling clock edge.
    int          cyc = 0;
    logic [2:0]  sck_p = '0, mosi_p = '0, ncs_p = '1, nldac_p = '1, busy_p = '0;
    int          bitn[3] = '{0, 0, 0};
    logic [15:0] sh[3];
    int          edges[3] = '{0, 0, 0};
    int          last_edge[3] = '{0, 0, 0};
    int          w_min[3] = '{1000, 1000, 1000};
    int          w_max[3] = '{0, 0, 0};
    int          mosi_chg[3] = '{-1000, -1000, -1000};
    int          last_rise[3] = '{-1000, -1000, -1000};
    int          su_min[3] = '{1000, 1000, 1000};
    int          ho_min[3] = '{1000, 1000, 1000};
    int          nl_fall[3] = '{0, 0, 0};
    int          nl_w[3] = '{0, 0, 0};
    int          b_rise[3] = '{0, 0, 0};
    int          busy_len[3] = '{0, 0, 0};
    int          seq_cnt[3] = '{0, 0, 0};
    int          bad_len[3] = '{0, 0, 0};
    int          fr_n[3] = '{0, 0, 0};
    logic [15:0] fr_log[3][32];

    always @(negedge clk) begin
        int w;
        for (int i = 0; i < 3; i++) begin
            if (!rstn_v[i]) begin
                bitn[i]  = 0;
                edges[i] = 0;
            end else begin
                if (ncs_p[i] && !ncs[i]) begin
                    bitn[i]  = 0;
                    edges[i] = 0;
                end
                if (sck[i] != sck_p[i]) begin
                    if (edges[i] > 0) begin
                        w = cyc - last_edge[i];
                        if (w < w_min[i]) w_min[i] = w;
                        if (w > w_max[i]) w_max[i] = w;
                    end
                    edges[i]++;
                    last_edge[i] = cyc;
                    if (sck[i]) begin
                        sh[i] = {sh[i][14:0], mosi[i]};
                        bitn[i]++;
                        if (cyc - mosi_chg[i] < su_min[i]) su_min[i] = cyc - mosi_chg[i];
                        last_rise[i] = cyc;
                    end
                end
                if (mosi[i] != mosi_p[i]) begin
                    if (cyc - last_rise[i] < ho_min[i]) ho_min[i] = cyc - last_rise[i];
                    mosi_chg[i] = cyc;
                end
                if (!ncs_p[i] && ncs[i]) begin
                    if (bitn[i] != 16) bad_len[i]++;
                    if (fr_n[i] < 32) fr_log[i][fr_n[i]] = sh[i];
                    fr_n[i]++;
                end
                if (nldac_p[i] && !nldac[i]) nl_fall[i] = cyc;
                if (!nldac_p[i] && nldac[i]) nl_w[i] = cyc - nl_fall[i];
                if (!busy_p[i] && busy[i]) b_rise[i] = cyc;
                if (busy_p[i] && !busy[i]) begin
                    busy_len[i] = cyc - b_rise[i];
                    seq_cnt[i]++;
                end
            end
        end
        sck_p   = sck;
        mosi_p  = mosi;
        ncs_p   = ncs;
        nldac_p = nldac;
        busy_p  = busy;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int rd = 0;
    task automatic expect_frame(input string tag, input logic [15:0] exp);
        logic [31:0] got;
        got = 32'hFFFF_FFFF;
        if (rd < fr_n[0] && rd < 32) got = {16'h0, fr_log[0][rd]};
        rd++;
        check(tag, got, {16'h0, exp});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; data_in = d; wr = 1'b1; req = 1'b1;
        @(negedge clk);
        req = 1'b0; wr = 1'b0;
        check("wr_ready", ready, 1);
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        address = a; wr = 1'b0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check({tag, "_ready"}, ready, 1);
        check(tag, data_out, exp);
        @(negedge clk);
        check({tag, "_ready_low"}, ready, 0);
    endtask

    task automatic wait_seqs(input int n, input string tag);
        int t = 0;
        while (seq_cnt[0] < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, seq_cnt[0] >= n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int t;
        int dv[3] = '{4, 1, 7};
        #1;
        nreset = 1'b0;
        nreset_s = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_data_out", data_out, 0);
        check("rst_sck", sck[0], 0);
        check("rst_mosi", mosi[0], 0);
        check("rst_ncs", ncs[0], 1);
        check("rst_nldac", nldac[0], 1);
        check("rst_busy", busy[0], 0);
        nreset = 1'b1;
        nreset_s = 1'b1;

        wait_seqs(1, "seq1_done");
        check("seq1_len", busy_len[0], 274);
        check("seq1_nldac", nl_w[0], 2);
        expect_frame("seq1_a", 16'h3400);
        expect_frame("seq1_b", 16'hBC00);
        bus_read(2'd0, 32'h400, "rd_lo_rst");
        bus_read(2'd1, 32'hC00, "rd_hi_rst");
        bus_read(2'd2, 32'h0, "rd_ctrl_idle");

        bus_write(2'd0, 32'hFFFF_F123);
        wait_seqs(2, "seq2_done");
        expect_frame("seq2_a", 16'h3123);
        expect_frame("seq2_b", 16'hBC00);
        bus_write(2'd1, 32'hABCD_EFED);
        wait_seqs(3, "seq3_done");
        expect_frame("seq3_a", 16'h3123);
        expect_frame("seq3_b", 16'hBFED);
        bus_read(2'd0, 32'h123, "rd_lo");
        bus_read(2'd1, 32'hFED, "rd_hi");

        bus_write(2'd2, 32'h1);
        repeat (8) @(negedge clk);
        bus_write(2'd0, 32'h0AA);
        bus_read(2'd2, 32'h3, "rd_ctrl_busy");
        bus_read(2'd3, 32'h0, "rd_addr3");
        repeat (80) @(negedge clk);
        bus_write(2'd1, 32'h055);
        wait_seqs(5, "seq5_done");
        expect_frame("seq4_a", 16'h3123);
        expect_frame("seq4_b", 16'hBFED);
        expect_frame("seq5_a", 16'h30AA);
        expect_frame("seq5_b", 16'hB055);
        repeat (300) @(negedge clk);
        check("no_extra_seq", seq_cnt[0], 5);
        check("idle_after", busy[0], 0);
        check("frame_count", fr_n[0], 10);

        @(negedge clk);
        address = 2'd0; data_in = 32'h7FF; wr = 1'b1; req = 1'b1;
        @(negedge clk);
        address = 2'd1; data_in = 32'h801;
        @(negedge clk);
        req = 1'b0; wr = 1'b0;
        wait_seqs(7, "seq7_done");
        expect_frame("seq6_a", 16'h37FF);
        expect_frame("seq6_b", 16'hB055);
        expect_frame("seq7_a", 16'h37FF);
        expect_frame("seq7_b", 16'hB801);

        base = seq_cnt[0];
        bus_write(2'd2, 32'h1);
        t = 0;
        while (bitn[0] < 9 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("bit7_reached", t < 500, 1);
        #2 nreset = 1'b0;
        #1;
        check("midrst_ncs", ncs[0], 1);
        check("midrst_sck", sck[0], 0);
        check("midrst_nldac", nldac[0], 1);
        check("midrst_busy", busy[0], 0);
        repeat (2) @(negedge clk);
        #2 nreset = 1'b1;
        wait_seqs(base + 1, "post_rst_done");
        check("post_rst_len", busy_len[0], 274);
        expect_frame("post_rst_a", 16'h3400);
        expect_frame("post_rst_b", 16'hBC00);
        bus_read(2'd0, 32'h400, "rd_lo_post_rst");

        for (int i = 0; i < 3; i++) begin
            check($sformatf("sck_wmin%0d", i), w_min[i], dv[i]);
            check($sformatf("sck_wmax%0d", i), w_max[i], dv[i]);
            check($sformatf("mosi_setup%0d", i), su_min[i] >= dv[i], 1);
            check($sformatf("mosi_hold%0d", i), ho_min[i] >= dv[i], 1);
            check($sformatf("frame_len%0d", i), bad_len[i], 0);
        end
        check("div1_len", busy_len[1], 70);
        check("div7_len", busy_len[2], 478);
        for (int i = 1; i < 3; i++) begin
            check($sformatf("sweep_seqs%0d", i), seq_cnt[i], 1);
            check($sformatf("sweep_frames%0d", i), fr_n[i], 2);
            check($sformatf("sweep_a%0d", i), fr_log[i][0], 16'h3400);
            check($sformatf("sweep_b%0d", i), fr_log[i][1], 16'hBC00);
            check($sformatf("sweep_nldac%0d", i), nl_w[i], 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/logic_probe_dac.md
Name: logic_probe_dac

Overview:
Threshold generator for the logic probe comparators. Holds the CPU-programmed low and high thresholds and drives a dual 12-bit SPI DAC (MCP4922-style frame) with them. DAC channel A produces DAC_OUT_LO and channel B produces DAC_OUT_HI. Sits upstream of the comparator/counter stage and on the same CPU peripheral bus with the same request/ready handshake.

Parameters:
CLK_DIV, 4, SCK half-period in clk cycles (>=1)
LDAC_CYCLES, 2, width of the nLDAC low pulse in clk cycles (>=1)
LO_RESET, 12'h400, reset value of the low threshold
HI_RESET, 12'hC00, reset value of the high threshold

Ports:
clk  in  1  system clock
nreset  in  1  asynchronous active-low reset
address  in  2  register select
data_in  in  32  write data
data_out  out  32  read data, registered
req  in  1  bus request, single-cycle pulse
wr  in  1  qualifies req: 1 = write, 0 = read
ready  out  1  bus acknowledge
dac_sck  out  1  SPI clock, idle low
dac_mosi  out  1  SPI data, MSB first
dac_ncs  out  1  DAC chip select, active low
dac_nldac  out  1  DAC latch strobe, active low
busy  out  1  an update sequence is in progress

Behaviour:
Clocking and reset:
- Single clock domain: clk.
- Reset is asynchronous and active-low on nreset.
- Reset values: thr_lo=LO_RESET, thr_hi=HI_RESET, pending=1 so thresholds are pushed to the DAC right after reset, ready=0, data_out=0, dac_sck=0, dac_mosi=0, dac_ncs=1, dac_nldac=1, busy=0, FSM=IDLE.

Bus:
- ready <= req. One-cycle latency, one-cycle pulse.
- Read: data_out loaded on the req cycle as follows:
  - addr 0: {20'h0, thr_lo}
  - addr 1: {20'h0, thr_hi}
  - addr 2: {30'h0, pending, busy}
  - addr 3: 0
- Write: the register updates on the req cycle as follows:
  - addr 0: thr_lo <= data_in[11:0], then set pending.
  - addr 1: thr_hi <= data_in[11:0], then set pending.
  - addr 2: data_in[0]=1 sets pending.
  - addr 3: ignored.
- data_out holds its value on writes.

Frame format, 16 bits:
- [15] channel (0=A, 1=B)
- [14] buf=0
- [13] gain=1
- [12] nshdn=1
- [11:0] value
- Frame A carries thr_lo; frame B carries thr_hi.

FSM states: IDLE, START, SHIFT, GAP, LDAC.
- IDLE: if pending, clear pending, snapshot thr_lo/thr_hi into shadow regs, set ch=0, go to START. busy=1 in all states except IDLE.
- START: dac_ncs=0, mosi=frame bit15. Wait CLK_DIV cycles, then go to SHIFT.
- SHIFT: 16 SCK periods. sck rises after each CLK_DIV half-period, then falls after the next. mosi updates on the falling edge (or on entry for bit 15). After the 16th falling edge, go to GAP.
- GAP: dac_ncs=1, sck=0 for CLK_DIV cycles. If ch=0, set ch=1 and go to START; otherwise go to LDAC.
- LDAC: dac_nldac=0 for LDAC_CYCLES cycles, then 1, then go to IDLE.

Timing and boundary cases:
- Total sequence = 2*(CLK_DIV + 32*CLK_DIV + CLK_DIV) + LDAC_CYCLES cycles. With defaults this is 274.
- A write during a sequence updates thr_* and sets pending. The current sequence finishes with its snapshot, then a second sequence runs. Any number of writes during one sequence produce exactly one extra sequence.
- A write landing in the same cycle IDLE consumes pending: set wins, so pending remains 1 and another sequence follows.
- Bus access is never stalled by the SPI activity.
- Reset mid-frame: outputs return immediately to idle levels and the sequence restarts from IDLE with pending=1.

Decomposition:
- Shared package (logic_probe_pkg): register address constants (ADDR_THR_LO=0, ADDR_THR_HI=1, ADDR_CTRL=2), DAC frame bit positions, and the FSM state encoding.
- One natural sub-module: spi_tx16, a 16-bit MSB-first shifter with CLK_DIV prescaler, start/done handshake, and sck/mosi outputs. The top module owns the registers, pending, the FSM, ncs and nldac.

Test Plan:
- Reset release -> one sequence with no bus activity: frames 0x3400 then 0xBC00 decoded on SPI, nLDAC low for 2 cycles, busy falls at cycle 274 ±1.
- Write addr0=0x123, wait idle, write addr1=0xFED -> two sequences: first frames 0x3123/0xBC00, second 0x3123/0xBFED. data_in[31:12] is ignored.
- Write addr0 at cycle 10 of a sequence, then addr1 at cycle 100 -> current frames unchanged; exactly one follow-on sequence carries both new values.
- Read addr2 mid-sequence with pending set -> data_out=3, ready high exactly one cycle after req. Read addr3 -> 0.
- Assert nreset at bit 7 of frame A -> dac_ncs=1, sck=0, nldac=1 immediately; after release, a complete sequence with the reset values follows.
- Sweep CLK_DIV=1 and CLK_DIV=7 -> SCK half-period equals CLK_DIV. MOSI is stable for at least CLK_DIV cycles around each rising edge.
